// File: rtl/fir_pkg.sv
// Shared constants, types and arithmetic helpers
// for the parametrised transposed-form FIR.
package fir_pkg;

  localparam int FIR_ADDR_W = 6;

  typedef enum logic {
    ST_FILL,
    ST_RUN
  } fir_st_e;

  function automatic int fir_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic int fir_acc_w(
    input int dw,
    input int cw,
    input int nt
  );
    return dw + cw + fir_clog2(nt);
  endfunction

  // Round half up, then arithmetic shift.
  function automatic logic signed [63:0] fir_round(
    input logic signed [63:0] acc,
    input int                 sh
  );
    logic signed [63:0] t;
    t = acc;
    if (sh > 0) t = t + (64'sd1 <<< (sh - 1));
    return t >>> sh;
  endfunction

  function automatic logic signed [63:0] fir_lim(
    input int   ow,
    input logic hi
  );
    logic signed [63:0] m;
    m = 64'sd1 <<< (ow - 1);
    return hi ? (m - 64'sd1) : -m;
  endfunction

endpackage

// File: rtl/fir_tpose_param_tap.sv
// One transposed-form stage:
// R_out <= x*b + R_in, with enable and sync clear.
module fir_tap
  import fir_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int ACC_W = 18
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_clr,
  input  logic signed [DW-1:0]    i_x,
  input  logic signed [CW-1:0]    i_b,
  input  logic signed [ACC_W-1:0] i_r,
  output logic signed [ACC_W-1:0] o_r
);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_prod;

  assign w_prod = ACC_W'(i_x) * ACC_W'(i_b);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_prod + i_r;
    end
  end

  assign o_r = r_acc;

endmodule

// File: rtl/fir_tpose_param.sv
// Transposed-form FIR: coefficient bank, tap-0 MAC,
// round/saturate output stage and priming FSM.
module fir_tpose_param
  import fir_pkg::*;
#(
  parameter int NTAPS     = 7,
  parameter int DW        = 8,
  parameter int CW        = 8,
  parameter int OW        = 16,
  parameter int OUT_SHIFT = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_in_valid,
  input  logic signed [DW-1:0]  i_xin,
  input  logic                  i_coef_we,
  input  logic [FIR_ADDR_W-1:0] i_coef_addr,
  input  logic signed [CW-1:0]  i_coef_data,
  output logic                  o_out_valid,
  output logic signed [OW-1:0]  o_yout,
  output logic                  o_sat
);

  localparam int ACC_W = fir_acc_w(DW, CW, NTAPS);
  localparam int CNT_W = fir_clog2(NTAPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NTAPS - 1);
  localparam logic signed [63:0] LIM_HI = fir_lim(OW, 1'b1);
  localparam logic signed [63:0] LIM_LO = fir_lim(OW, 1'b0);
  localparam logic signed [OW-1:0] Y_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] Y_MIN = {1'b1, {(OW-1){1'b0}}};

  logic signed [CW-1:0]    r_coef [NTAPS];
  logic signed [ACC_W-1:0] w_r [1:NTAPS];
  logic signed [ACC_W-1:0] w_acc;
  logic signed [63:0]      w_rnd;
  logic signed [OW-1:0]    w_y;
  logic                    w_hi;
  logic                    w_lo;
  logic                    w_en;

  fir_st_e          r_st;
  fir_st_e          w_st_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_vld_nx;

  logic                 r_vld;
  logic signed [OW-1:0] r_yout;
  logic                 r_sat;

  assign w_en = i_in_valid & ~i_clear;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NTAPS; k++) r_coef[k] <= '0;
    end else if (i_coef_we) begin
      for (int k = 0; k < NTAPS; k++) begin
        if (i_coef_addr == FIR_ADDR_W'(k)) r_coef[k] <= i_coef_data;
      end
    end
  end

  assign w_r[NTAPS] = '0;

  for (genvar k = 1; k < NTAPS; k++) begin : g_tap
    fir_tap #(
      .DW   (DW),
      .CW   (CW),
      .ACC_W(ACC_W)
    ) u_tap (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_en (w_en),
      .i_clr(i_clear),
      .i_x  (i_xin),
      .i_b  (r_coef[k]),
      .i_r  (w_r[k+1]),
      .o_r  (w_r[k])
    );
  end

  assign w_acc = ACC_W'(i_xin) * ACC_W'(r_coef[0]) + w_r[1];
  assign w_rnd = fir_round(64'(w_acc), OUT_SHIFT);
  assign w_hi  = w_rnd > LIM_HI;
  assign w_lo  = w_rnd < LIM_LO;
  assign w_y   = w_hi ? Y_MAX : (w_lo ? Y_MIN : w_rnd[OW-1:0]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_st  <= ST_FILL;
      r_cnt <= '0;
    end else begin
      r_st  <= w_st_nx;
      r_cnt <= w_cnt_nx;
    end
  end

  // The NTAPS-th accept after a flush fills every tap and is the first output.
  always_comb begin
    w_st_nx  = r_st;
    w_cnt_nx = r_cnt;
    w_vld_nx = 1'b0;
    if (i_clear) begin
      w_st_nx  = ST_FILL;
      w_cnt_nx = '0;
    end else if (i_in_valid) begin
      unique case (r_st)
        ST_FILL: begin
          if (r_cnt == CNT_LAST) begin
            w_st_nx  = ST_RUN;
            w_vld_nx = 1'b1;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
        ST_RUN: w_vld_nx = 1'b1;
        default: w_st_nx = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld  <= 1'b0;
      r_yout <= '0;
      r_sat  <= 1'b0;
    end else begin
      r_vld <= w_vld_nx;
      if (w_en) begin
        r_yout <= w_y;
        r_sat  <= w_hi | w_lo;
      end
    end
  end

  assign o_out_valid = r_vld;
  assign o_yout      = r_yout;
  assign o_sat       = r_sat;

endmodule

// File: tb/tb_fir_tpose_param.sv
// Scoreboard bench: two DUTs (OUT_SHIFT 0 and 6), directed
// vectors push expected outputs, one monitor pops and compares.
module tb_fir_tpose_param;

  typedef struct {
    logic signed [15:0] y;
    logic               s;
  } exp_t;

  logic clk;
  logic rst;
  logic clear;
  logic vin0, vin6;
  logic we0, we6;
  logic signed [7:0] xin;
  logic [5:0] addr;
  logic signed [7:0] cdat;

  logic ov0, ov6;
  logic signed [15:0] y0, y6;
  logic s0, s6;

  exp_t q0[$];
  exp_t q6[$];
  int   tests;
  int   fails;
  bit   done;

  fir_tpose_param #(
    .NTAPS(4), .DW(8), .CW(8), .OW(16), .OUT_SHIFT(0)
  ) u_dut0 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clear    (clear),
    .i_in_valid (vin0),
    .i_xin      (xin),
    .i_coef_we  (we0),
    .i_coef_addr(addr),
    .i_coef_data(cdat),
    .o_out_valid(ov0),
    .o_yout     (y0),
    .o_sat      (s0)
  );

  fir_tpose_param #(
    .NTAPS(4), .DW(8), .CW(8), .OW(16), .OUT_SHIFT(6)
  ) u_dut6 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clear    (clear),
    .i_in_valid (vin6),
    .i_xin      (xin),
    .i_coef_we  (we6),
    .i_coef_addr(addr),
    .i_coef_data(cdat),
    .o_out_valid(ov6),
    .o_yout     (y6),
    .o_sat      (s6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      tests++;
      if (y0 !== 16'sd0 || ov0 !== 1'b0 || s0 !== 1'b0) begin
        fails++;
        $display("FAIL rst_dut0 got y=%0d v=%b s=%b want 0 0 0", y0, ov0, s0);
      end
      tests++;
      if (y6 !== 16'sd0 || ov6 !== 1'b0 || s6 !== 1'b0) begin
        fails++;
        $display("FAIL rst_dut6 got y=%0d v=%b s=%b want 0 0 0", y6, ov6, s6);
      end
    end else begin
      if (ov0 === 1'b1) begin
        tests++;
        if (q0.size() == 0) begin
          fails++;
          $display("FAIL dut0_spurious got y=%0d want no output", y0);
        end else begin
          e = q0.pop_front();
          if (y0 !== e.y || s0 !== e.s) begin
            fails++;
            $display("FAIL dut0_out got y=%0d s=%b want y=%0d s=%b", y0, s0, e.y, e.s);
          end
        end
      end
      if (ov6 === 1'b1) begin
        tests++;
        if (q6.size() == 0) begin
          fails++;
          $display("FAIL dut6_spurious got y=%0d want no output", y6);
        end else begin
          e = q6.pop_front();
          if (y6 !== e.y || s6 !== e.s) begin
            fails++;
            $display("FAIL dut6_out got y=%0d s=%b want y=%0d s=%b", y6, s6, e.y, e.s);
          end
        end
      end
      if (done) begin
        tests++;
        if (q0.size() != 0 || q6.size() != 0) begin
          fails++;
          $display("FAIL missing_out got pending %0d/%0d want 0/0", q0.size(), q6.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input int a, input int d);
    we0 = 1'b1; addr = 6'(a); cdat = 8'(d);
    tick();
    we0 = 1'b0;
  endtask

  task automatic wr6(input int a, input int d);
    we6 = 1'b1; addr = 6'(a); cdat = 8'(d);
    tick();
    we6 = 1'b0;
  endtask

  task automatic acc0(input int x, input bit e, input int y, input bit s);
    vin0 = 1'b1; xin = 8'(x);
    if (e) q0.push_back('{16'(y), s});
    tick();
    vin0 = 1'b0;
  endtask

  task automatic acc6(input int x, input bit e, input int y, input bit s);
    vin6 = 1'b1; xin = 8'(x);
    if (e) q6.push_back('{16'(y), s});
    tick();
    vin6 = 1'b0;
  endtask

  task automatic flush();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int ramp[5];
    rst = 1'b1; clear = 1'b0; vin0 = 1'b0; vin6 = 1'b0;
    we0 = 1'b0; we6 = 1'b0; xin = '0; addr = '0; cdat = '0;
    done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // impulse response after priming with zeros
    wr0(0, 1); wr0(1, 2); wr0(2, 3); wr0(3, 4);
    for (int i = 0; i < 3; i++) acc0(0, 0, 0, 0);
    acc0(0, 1, 0, 0);
    acc0(1, 1, 1, 0);
    acc0(0, 1, 2, 0);
    acc0(0, 1, 3, 0);
    acc0(0, 1, 4, 0);
    acc0(0, 1, 0, 0);

    // gapped input: outputs only after accepts, history intact
    ramp = '{10, 30, 60, 100, 100};
    for (int i = 0; i < 5; i++) begin
      acc0(10, 1, ramp[i], 0);
      tick();
    end

    // saturation at both rails, and just inside them
    flush();
    for (int k = 0; k < 4; k++) wr0(k, 127);
    for (int i = 0; i < 3; i++) acc0(127, 0, 0, 0);
    acc0(127, 1, 32767, 1);
    acc0(127, 1, 32767, 1);
    acc0(-128, 1, 32131, 0);
    acc0(-128, 1, -254, 0);
    acc0(-128, 1, -32639, 0);
    acc0(-128, 1, -32768, 1);

    // coefficient write coincident with an accept uses the old value
    flush();
    for (int k = 0; k < 4; k++) wr0(k, 1);
    for (int i = 0; i < 3; i++) acc0(1, 0, 0, 0);
    acc0(1, 1, 4, 0);
    acc0(1, 1, 4, 0);
    we0 = 1'b1; addr = 6'd2; cdat = 8'sd5;
    acc0(1, 1, 4, 0);
    we0 = 1'b0;
    acc0(1, 1, 4, 0);
    acc0(1, 1, 4, 0);
    acc0(1, 1, 8, 0);
    wr0(9, 100);
    acc0(1, 1, 8, 0);
    acc0(1, 1, 8, 0);

    // clear with a same-cycle sample drops it and re-primes
    clear = 1'b1; vin0 = 1'b1; xin = 8'sd7;
    tick();
    clear = 1'b0; vin0 = 1'b0;
    acc0(1, 0, 0, 0);
    acc0(2, 0, 0, 0);
    acc0(3, 0, 0, 0);
    acc0(4, 1, 18, 0);
    acc0(5, 1, 26, 0);

    // OUT_SHIFT=6 rounding
    wr6(0, 64);
    for (int i = 0; i < 3; i++) acc6(3, 0, 0, 0);
    acc6(3, 1, 3, 0);
    acc6(3, 1, 3, 0);
    wr6(0, 32);
    acc6(1, 1, 1, 0);
    acc6(-1, 1, 0, 0);
    acc6(-3, 1, -1, 0);
    tick();
    tick();

    // async reset between edges
    @(posedge clk);
    #3 rst = 1'b1;
    #4 rst = 1'b0;
    tick();
    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("FAIL monitor_timeout got no summary want summary");
    $fatal(1, "monitor did not finish");
  end

endmodule
